// File: rtl/phy_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : phy_tx_framer
// Purpose  : Frames 32-bit payload words into a byte stream for an 8:1 DDR
//            output serializer (CLKDIV domain). Inserts SOF/EOF, FILL on
//            mid-frame underrun, IDLE between frames and a training pattern
//            after reset or on request.
// Revision : 1.0 - initial release
// ============================================================================
module phy_tx_framer #(
  parameter int         DATA_WIDTH    = 8,
  parameter int         TRAIN_CYCLES  = 64,
  parameter logic [7:0] TRAIN_PATTERN = 8'hB5,
  parameter logic [7:0] SOF_BYTE      = 8'hBC,
  parameter logic [7:0] EOF_BYTE      = 8'hFD,
  parameter logic [7:0] FILL_BYTE     = 8'h7C,
  parameter logic [7:0] IDLE_BYTE     = 8'h00,
  parameter int         CNT_WIDTH     = 16
) (
  input  logic                  i_clk_div_in,
  input  logic                  i_reset_n,
  input  logic                  i_train_req,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [31:0]           i_s_data,
  input  logic                  i_s_last,
  output logic [DATA_WIDTH-1:0] o_data_to_phy,
  output logic                  o_link_trained,
  output logic [CNT_WIDTH-1:0]  o_frame_cnt
);

  // Training counter must hold values 0..TRAIN_CYCLES-1.
  localparam int            c_TCW        = (TRAIN_CYCLES > 1) ? $clog2(TRAIN_CYCLES) : 1;
  localparam logic [c_TCW-1:0] c_TRAIN_LAST = c_TCW'(TRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_TRAIN = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SOF   = 3'd2,
    ST_DATA  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_EOF   = 3'd5
  } state_t;

  state_t                r_state;
  logic [c_TCW-1:0]      r_train_cnt;
  logic [31:0]           r_shreg;
  logic [1:0]            r_byte_idx;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_link_trained;
  logic [CNT_WIDTH-1:0]  r_frame_cnt;
  logic [7:0]            w_cur_byte;

  // Select the payload byte currently addressed in the shift register (LSB first).
  always_comb begin
    w_cur_byte = r_shreg[7:0];
    case (r_byte_idx)
      2'd0:    w_cur_byte = r_shreg[7:0];
      2'd1:    w_cur_byte = r_shreg[15:8];
      2'd2:    w_cur_byte = r_shreg[23:16];
      default: w_cur_byte = r_shreg[31:24];
    endcase
  end

  // Ready depends on registered state only, never on i_s_valid.
  assign o_s_ready = (r_state == ST_SOF) || (r_state == ST_WAIT) ||
                     ((r_state == ST_DATA) && (r_byte_idx == 2'd3) && !r_last);

  // Framer state machine with registered byte output, training flag and frame counter.
  always_ff @(posedge i_clk_div_in or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= ST_TRAIN;
      r_train_cnt    <= '0;
      r_shreg        <= '0;
      r_byte_idx     <= '0;
      r_last         <= 1'b0;
      r_data         <= '0;
      r_link_trained <= 1'b0;
      r_frame_cnt    <= '0;
    end else begin
      case (r_state)
        ST_TRAIN: begin
          r_data <= TRAIN_PATTERN;
          if (r_train_cnt == c_TRAIN_LAST) begin
            r_train_cnt <= '0;
            r_state     <= ST_IDLE;
            // An aborting request means this run did not complete.
            if (!i_train_req) r_link_trained <= 1'b1;
          end else begin
            r_train_cnt <= r_train_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          r_data <= IDLE_BYTE;
          if (i_s_valid) r_state <= ST_SOF;
        end
        ST_SOF: begin
          r_data <= SOF_BYTE;
          if (i_s_valid) begin
            r_shreg    <= i_s_data;
            r_last     <= i_s_last;
            r_byte_idx <= 2'd0;
            r_state    <= ST_DATA;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_DATA: begin
          r_data <= w_cur_byte;
          if (r_byte_idx != 2'd3) begin
            r_byte_idx <= r_byte_idx + 2'd1;
          end else if (r_last) begin
            r_state <= ST_EOF;
          end else if (i_s_valid) begin
            // Back-to-back word: no gap between the two words on the wire.
            r_shreg    <= i_s_data;
            r_last     <= i_s_last;
            r_byte_idx <= 2'd0;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_data <= FILL_BYTE;
          if (i_s_valid) begin
            r_shreg    <= i_s_data;
            r_last     <= i_s_last;
            r_byte_idx <= 2'd0;
            r_state    <= ST_DATA;
          end
        end
        ST_EOF: begin
          r_data  <= EOF_BYTE;
          r_state <= ST_IDLE;
          // A frame aborted by a training request is not counted.
          if (!i_train_req) r_frame_cnt <= r_frame_cnt + 1'b1;
        end
        default: begin
          r_data  <= IDLE_BYTE;
          r_state <= ST_IDLE;
        end
      endcase

      // Training request overrides every other transition.
      if (i_train_req) begin
        r_state     <= ST_TRAIN;
        r_train_cnt <= '0;
      end
    end
  end

  assign o_data_to_phy  = r_data;
  assign o_link_trained = r_link_trained;
  assign o_frame_cnt    = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_phy_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_tx_framer
// Purpose  : Scoreboard bench for phy_tx_framer. The stimulus side turns each
//            frame into the byte stream the link should carry (SOF, fills,
//            payload LSB first, EOF) and queues it; a monitor drops IDLE and
//            training bytes from the wire and compares the rest in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phy_tx_framer;

  localparam int         TRAIN_N = 64;
  localparam int         CNT_MOD = 4;   // DUT built with a 2-bit frame counter
  localparam logic [7:0] B_TRAIN = 8'hB5;
  localparam logic [7:0] B_SOF   = 8'hBC;
  localparam logic [7:0] B_EOF   = 8'hFD;
  localparam logic [7:0] B_FILL  = 8'h7C;
  localparam logic [7:0] B_IDLE  = 8'h00;

  logic        i_clk_div_in;
  logic        i_reset_n;
  logic        i_train_req;
  logic        i_s_valid;
  logic        o_s_ready;
  logic [31:0] i_s_data;
  logic        i_s_last;
  logic [7:0]  o_data_to_phy;
  logic        o_link_trained;
  logic [1:0]  o_frame_cnt;

  phy_tx_framer #(.CNT_WIDTH(2)) dut (
    .i_clk_div_in  (i_clk_div_in),
    .i_reset_n     (i_reset_n),
    .i_train_req   (i_train_req),
    .i_s_valid     (i_s_valid),
    .o_s_ready     (o_s_ready),
    .i_s_data      (i_s_data),
    .i_s_last      (i_s_last),
    .o_data_to_phy (o_data_to_phy),
    .o_link_trained(o_link_trained),
    .o_frame_cnt   (o_frame_cnt)
  );

  initial begin
    i_clk_div_in = 1'b0;
    forever #5 i_clk_div_in = ~i_clk_div_in;
  end

  typedef struct {
    logic [7:0] b;
    bit         eof;
    int         cnt;   // frame count expected alongside this EOF
    int         rdy;   // ready-high cycles expected since reset at this EOF
  } tok_t;

  tok_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_frames = 0;
  int   exp_ready  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_tok(input logic [7:0] b, input bit eof);
    tok_t t;
    t.b = b; t.eof = eof; t.cnt = exp_frames; t.rdy = exp_ready;
    sb.push_back(t);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    do b = 8'($urandom_range(1, 255));
    while (b == B_FILL || b == B_TRAIN || b == B_SOF || b == B_EOF);
    return b;
  endfunction

  function automatic logic [31:0] rand_word();
    return {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
  endfunction

  task automatic check_reset_outputs();
    check("rst_data",  int'(o_data_to_phy),  0);
    check("rst_ready", int'(o_s_ready),      0);
    check("rst_link",  int'(o_link_trained), 0);
    check("rst_cnt",   int'(o_frame_cnt),    0);
  endtask

  // Present one word. For the first word of a frame, d is idle cycles before
  // presenting; for later words, d is ready-high cycles left unanswered.
  // Called and returns at posedge+1.
  task automatic send_word(input logic [31:0] w, input logic l, input int d, input bit first);
    int seen;
    int guard;
    bit got;
    i_s_valid = 1'b0;
    seen = 0;
    guard = 0;
    if (first) begin
      repeat (d) begin @(posedge i_clk_div_in); #1; end
    end else begin
      while (seen < d && guard < 300) begin
        @(negedge i_clk_div_in);
        if (o_s_ready) seen++;
        @(posedge i_clk_div_in); #1;
        guard++;
      end
      if (seen < d) check("underrun_timeout", seen, d);
    end
    i_s_valid = 1'b1; i_s_data = w; i_s_last = l;
    got = 1'b0;
    guard = 0;
    while (!got && guard < 500) begin
      @(negedge i_clk_div_in);
      got = o_s_ready;
      @(posedge i_clk_div_in); #1;
      guard++;
    end
    if (!got) check("accept_timeout", 0, 1);
    i_s_valid = 1'b0;
  endtask

  // Issue one complete frame: queue its expected wire image, then drive it.
  task automatic send_frame(input int n, input int dmax, input int dfix, input int gap0,
                            input logic [31:0] w0, input bit use_w0);
    logic [31:0] w[$];
    int          d[$];
    int          dsum;
    dsum = 0;
    for (int i = 0; i < n; i++) begin
      w.push_back((i == 0 && use_w0) ? w0 : rand_word());
      d.push_back((i == 0) ? 0 : ((dfix >= 0) ? dfix : int'($urandom_range(0, dmax))));
      dsum += d[i];
    end
    push_tok(B_SOF, 1'b0);
    for (int i = 0; i < n; i++) begin
      for (int f = 0; f < d[i]; f++) push_tok(B_FILL, 1'b0);
      for (int k = 0; k < 4; k++) push_tok(w[i][8*k +: 8], 1'b0);
    end
    exp_frames = (exp_frames + 1) % CNT_MOD;
    exp_ready  = exp_ready + n + dsum;   // SOF, one per later word, plus each unanswered cycle
    push_tok(B_EOF, 1'b1);
    for (int i = 0; i < n; i++)
      send_word(w[i], (i == n - 1), (i == 0) ? gap0 : d[i], (i == 0));
  endtask

  // Monitor: one output byte per cycle, sampled mid-cycle.
  initial begin : mon
    int         run;
    int         rdy_seen;
    bit         trained;
    logic [7:0] b;
    tok_t       t;
    run = 0; rdy_seen = 0; trained = 1'b0;
    forever begin
      @(negedge i_clk_div_in);
      if (!i_reset_n) begin
        run = 0; rdy_seen = 0; trained = 1'b0;
      end else begin
        if (o_s_ready) rdy_seen++;
        b = o_data_to_phy;
        if (b == B_TRAIN) begin
          if (run == 0) check("train_start_link", int'(o_link_trained), int'(trained));
          run++;
        end else begin
          if (run != 0) begin
            check("train_len", run, TRAIN_N);
            check("train_done_link", int'(o_link_trained), 1);
            trained = 1'b1;
            run = 0;
          end
          if (b != B_IDLE) begin
            if (sb.size() == 0) begin
              check("unexpected_byte", int'(b), int'(B_IDLE));
            end else begin
              t = sb.pop_front();
              check("wire_byte", int'(b), int'(t.b));
              if (t.eof) begin
                check("frame_cnt", int'(o_frame_cnt), t.cnt);
                check("ready_cycles", rdy_seen, t.rdy);
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] w;
    int          g;
    i_reset_n = 1'b1; i_train_req = 1'b0; i_s_valid = 1'b0;
    i_s_data = '0; i_s_last = 1'b0;
    #1 i_reset_n = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge i_clk_div_in);
    #1 i_reset_n = 1'b1;

    // Training run followed by idle with no traffic
    repeat (80) @(posedge i_clk_div_in);
    #1;

    // Single-word frame with known content
    send_frame(1, 0, 0, 2, 32'h44332211, 1'b1);
    // Three words back to back
    send_frame(3, 0, 0, 1, '0, 1'b0);
    // Second word late by three ready cycles
    send_frame(2, 0, 3, 0, '0, 1'b0);
    // Randomized frames
    for (int i = 0; i < 20; i++)
      send_frame(int'($urandom_range(1, 5)), 3, -1, int'($urandom_range(0, 4)), '0, 1'b0);
    // Five one-word frames to walk the counter through its wrap
    for (int i = 0; i < 5; i++)
      send_frame(1, 0, 0, 0, '0, 1'b0);

    // Training request while the second payload byte is chosen
    w = rand_word();
    push_tok(B_SOF, 1'b0);
    push_tok(w[7:0], 1'b0);
    push_tok(w[15:8], 1'b0);
    exp_ready = exp_ready + 1;
    send_word(w, 1'b1, 0, 1'b1);          // accepted at the SOF edge
    @(posedge i_clk_div_in); #1;          // first payload byte emitted
    i_train_req = 1'b1;
    @(posedge i_clk_div_in); #1;          // second payload byte emitted, back to training
    i_train_req = 1'b0;
    for (int i = 0; i < 3; i++)
      send_frame(int'($urandom_range(1, 3)), 2, -1, int'($urandom_range(0, 3)), '0, 1'b0);

    // Reset in the middle of a frame
    w = rand_word();
    push_tok(B_SOF, 1'b0);
    exp_ready = exp_ready + 1;
    send_word(w, 1'b0, 1, 1'b1);
    @(posedge i_clk_div_in); #1;
    #2;
    i_reset_n = 1'b0;
    sb.delete();
    exp_ready = 0;
    exp_frames = 0;
    #1 check_reset_outputs();
    @(negedge i_clk_div_in);
    #1 i_reset_n = 1'b1;
    for (int i = 0; i < 2; i++)
      send_frame(int'($urandom_range(1, 3)), 2, -1, 0, '0, 1'b0);

    // Let the queued bytes reach the wire
    g = 0;
    while (sb.size() != 0 && g < 300) begin
      @(posedge i_clk_div_in);
      g++;
    end
    repeat (5) @(posedge i_clk_div_in);
    check("drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
